// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the state enum, opcode/funct values, select encodings and the per-state control table.
package mc_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPEEX  = 4'd6,
        S_RTYPEWB  = 4'd7,
        S_BRANCHEX = 4'd8,
        S_IMMEX    = 4'd9,
        S_IMMWB    = 4'd10,
        S_JEX      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control fields that depend on the state alone; these are registered in the top.
    typedef struct packed {
        u1          iord;
        u1          memwrite;
        u1          irwrite;
        u1          regdst;
        u1          memtoreg;
        u1          regwrite;
        u1          alusrca;
        u1          pcwrite;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.pcsrc   = PCSRC_ALU;
                c.pcwrite = 1'b1;
            end
            S_DECODE:   c.alusrcb = SRCB_IMMSH2;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMRD:    c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
            end
            S_RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCHEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.pcsrc   = PCSRC_ALUOUT;
            end
            S_IMMEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_IMMWB:    c.regwrite = 1'b1;
            S_JEX: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic u1 opcode_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU operation decoder: picks the ALU op for the current state from opcode/funct,
// and flags R-type instructions whose funct is not supported.
module mc_aludec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output u1          funct_illegal
);

    logic [2:0] funct_alu;
    logic [2:0] imm_alu;

    always_comb begin
        funct_alu     = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_illegal = (opcode == OP_RTYPE);
        endcase
    end

    always_comb begin
        imm_alu = ALU_ADD;
        case (opcode)
            OP_ANDI: imm_alu = ALU_AND;
            OP_ORI:  imm_alu = ALU_OR;
            OP_SLTI: imm_alu = ALU_SLT;
            default: imm_alu = ALU_ADD;
        endcase
    end

    // States that do not use the ALU drive 000.
    always_comb begin
        alucontrol = 3'b000;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR: alucontrol = ALU_ADD;
            S_RTYPEEX:                   alucontrol = funct_alu;
            S_BRANCHEX:                  alucontrol = ALU_SUB;
            S_IMMEX:                     alucontrol = imm_alu;
            default:                     alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS cpu: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and enable.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    state_t state_sel;
    ctrl_t  ctrl_q;
    u1      started_q;
    u1      funct_illegal;
    u1      branch_taken;

    mc_aludec u_aludec (
        .state         (state_q),
        .opcode        (opcode),
        .funct         (funct),
        .alucontrol    (alucontrol),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_RTYPE:                          state_d = funct_illegal ? S_FETCH : S_RTYPEEX;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCHEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
                    OP_J:                              state_d = S_JEX;
                    default:                           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_IMMEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // The first edge after reset release loads RESET_STATE's outputs without advancing,
    // so that state is actually seen with its enables asserted for one cycle.
    assign state_sel = started_q ? state_d : state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RESET_STATE;
            ctrl_q    <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_sel;
            ctrl_q    <= state_ctrl(state_sel);
            started_q <= 1'b1;
        end
    end

    assign branch_taken = (state_q == S_BRANCHEX) &&
                          (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero));

    assign pcen     = ctrl_q.pcwrite | branch_taken;
    assign iord     = ctrl_q.iord;
    assign memwrite = ctrl_q.memwrite;
    assign irwrite  = ctrl_q.irwrite;
    assign regdst   = ctrl_q.regdst;
    assign memtoreg = ctrl_q.memtoreg;
    assign regwrite = ctrl_q.regwrite;
    assign alusrca  = ctrl_q.alusrca;
    assign alusrcb  = ctrl_q.alusrcb;
    assign pcsrc    = ctrl_q.pcsrc;
    assign illegal  = (state_q == S_DECODE) && (!opcode_legal(opcode) || funct_illegal);
    assign state    = state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle MIPS `cpu`. It sequences the shared datapath (single memory, single ALU, instruction register) through fetch, decode, execute, memory and writeback states. It produces every mux select, write enable and ALU operation for the current cycle. It sits between the instruction register (`opcode`/`funct`) and the datapath, next to the ALU `zero` flag.

## Interface
Parameters:
- `RESET_STATE`, default `S_FETCH`: state entered on reset.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low. `reset`=0 forces `RESET_STATE` immediately.
- `opcode`  in  6  instr[31:26], valid from DECODE onward (IR stable).
- `funct`  in  6  instr[5:0].
- `zero`  in  1  ALU zero flag, sampled in the branch execute state.
- `pcen`  out  1  PC register enable, = `pcwrite | (branch & zero) | (bne & ~zero)`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  data memory write strobe.
- `irwrite`  out  1  instruction register load.
- `regdst`  out  1  write register: 0 = rt, 1 = rd.
- `memtoreg`  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- `regwrite`  out  1  register file write.
- `alusrca`  out  1  0 = PC, 1 = A.
- `alusrcb`  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported opcode or R-type funct.
- `state`  out  4  current state, debug only.

## Operation
- Moore FSM. All outputs decode from `state`, plus `opcode`/`funct` for `alucontrol`, `illegal` and the `pcen` branch term. Outputs not listed for a state are 0.
- FETCH: `iord`=0, `irwrite`=1, `alusrca`=0, `alusrcb`=01, add, `pcsrc`=00, `pcwrite`=1. Next state is DECODE.
- DECODE: `alusrcb`=11, add (branch target into ALUOut). Next state by opcode:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → RTYPEEX
  - beq 000100 or bne 000101 → BRANCHEX
  - addi 001000, andi 001100, ori 001101, slti 001010 → IMMEX
  - j 000010 → JEX
  - any other opcode → FETCH with `illegal`=1
- MEMADR: `alusrca`=1, `alusrcb`=10, add. lw → MEMRD; sw → MEMWR.
- MEMRD: `iord`=1. Next state MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1. Next state FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Next state FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, op from `funct`: add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111. Next state RTYPEWB.
- RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1. Next state FETCH.
- BRANCHEX: `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01. `branch` is set for beq, `bne` for bne. Next state FETCH.
- IMMEX: `alusrca`=1, `alusrcb`=10. Op by opcode: addi add, andi and, ori or, slti slt. Next state IMMWB.
- IMMWB: `regdst`=0, `memtoreg`=0, `regwrite`=1. Next state FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1. Next state FETCH.
- An unknown funct in DECODE with opcode 000000 also pulses `illegal`, and the FSM proceeds to FETCH (no writeback).
- andi/ori zero-extension is the datapath's concern. This block only selects `alusrcb`=10.

## Timing
- Reset values, held while `reset`=0: `state`=FETCH, all enables 0. FETCH outputs assert from the first rising edge after release.
- Release of `reset` is used only through the datapath's synchronizer; this block takes no action beyond the async clear.
- Instruction latency in cycles:
  - lw 5
  - sw 4
  - R-type 4
  - imm-ALU 4
  - beq/bne 3
  - j 3
  - illegal 2
- `pcen` in BRANCHEX depends combinationally on `zero` within the same cycle. The PC updates at the closing edge of that state.
- `memwrite` is high for exactly one cycle per sw.
- Asserting `reset` mid-instruction (e.g. in MEMWR) drops `memwrite` and `regwrite` asynchronously, with no partial-cycle glitch beyond the reset edge.

## Structure
- Shared package `mc_pkg`:
  - `state_t` enum, 4-bit
  - opcode and funct localparams
  - `alucontrol` encodings
  - `alusrcb`/`pcsrc` select encodings
- Use `u1`/`u32` from `common.svh`.
- Sub-module `mc_aludec`: combinational `(state, opcode, funct) → alucontrol, funct_illegal`.
- FSM register and output decode live in `multicycle_ctrl`.

## Test plan
- Reset held 3 cycles, then released: `state`=FETCH, `irwrite`=`pcen`=1 in the first cycle. Hold `reset`=0 mid-cycle: all enables 0 immediately.
- lw (100011): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=1 and `memtoreg`=1 only in MEMWB, over 5 cycles.
- sw (101011) driving the full `cpu` on the sequence program: exactly three `memwrite` pulses, to addr 80 (data 7), 84 (data 7), 88 (data 9). No other store address.
- beq with `zero`=1 → `pcen`=1 in BRANCHEX. Then with `zero`=0 → `pcen`=0. Repeat for bne with the opposite result.
- R-type funct 101010 → `alucontrol`=111 in RTYPEEX. funct 000111 → `illegal` pulse in DECODE, return to FETCH with no `regwrite`.
- ori (001101) → `alucontrol`=001, `alusrcb`=10. Opcode 111111 → `illegal`=1 for one cycle, 2-cycle instruction.
